uart_xcvr: RTL

//  Parametrised full-duplex UART transceiver for the Pi <-> FPGA header link: TX serialiser, RX deserialiser, RX FIFO.

---
 rtl/uart_xcvr.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_xcvr.sv
// Full-duplex 8N1-style UART: TX serialiser, RX deserialiser with 2-flop sync, show-ahead RX FIFO.
// Runtime loopback routes rx_pin straight to tx_pin while the TX FSM keeps handshaking.
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            loopback,
  input  logic                            rx_pin,
  output logic                            tx_pin,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            frame_err,
  output logic                            rx_overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                tx_state;
  logic [TW-1:0]         tx_timer;
  logic [BW-1:0]         tx_idx;
  logic [DATA_BITS-1:0]  tx_shreg;
  logic                  tx_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: if (tx_valid && tx_ready) begin
          tx_shreg <= tx_data;
          tx_line  <= 1'b0;
          tx_ready <= 1'b0;
          tx_timer <= '0;
          tx_state <= START;
        end
        START: if (tx_timer == T_LAST) begin
          tx_timer <= '0;
          tx_idx   <= '0;
          tx_line  <= tx_shreg[0];
          tx_state <= DATA;
        end else tx_timer <= tx_timer + 1'b1;
        DATA: if (tx_timer == T_LAST) begin
          tx_timer <= '0;
          if (tx_idx == B_LAST) begin
            tx_line  <= 1'b1;
            tx_state <= STOP;
          end else begin
            tx_idx   <= tx_idx + 1'b1;
            tx_shreg <= tx_shreg >> 1;
            tx_line  <= tx_shreg[1];
          end
        end else tx_timer <= tx_timer + 1'b1;
        STOP: if (tx_timer == T_LAST) begin
          tx_timer <= '0;
          tx_ready <= 1'b1;
          tx_state <= IDLE;
        end else tx_timer <= tx_timer + 1'b1;
        default: tx_state <= IDLE;
      endcase
    end
  end

  assign tx_pin = loopback ? rx_pin : tx_line;

  // rx_pin is asynchronous; only rx_bit (second flop) feeds decisions
  logic [1:0]           rx_sync;
  logic                 rx_bit;
  state_t               rx_state;
  logic [TW-1:0]        rx_timer;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 push;

  assign rx_bit = rx_sync[1];
  assign push   = (rx_state == STOP) && (rx_timer == T_LAST) && rx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync   <= 2'b11;
      rx_state  <= IDLE;
      rx_timer  <= '0;
      rx_idx    <= '0;
      rx_shreg  <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], rx_pin};
      frame_err <= 1'b0;
      case (rx_state)
        IDLE: if (!rx_bit) begin
          rx_timer <= '0;
          rx_state <= START;
        end
        START: if (rx_timer == T_HALF) begin
          rx_timer <= '0;
          rx_idx   <= '0;
          rx_state <= rx_bit ? IDLE : DATA;
        end else rx_timer <= rx_timer + 1'b1;
        DATA: if (rx_timer == T_LAST) begin
          rx_timer <= '0;
          rx_shreg <= {rx_bit, rx_shreg[DATA_BITS-1:1]};
          if (rx_idx == B_LAST) rx_state <= STOP;
          else rx_idx <= rx_idx + 1'b1;
        end else rx_timer <= rx_timer + 1'b1;
        STOP: if (rx_timer == T_LAST) begin
          rx_timer  <= '0;
          frame_err <= !rx_bit;
          rx_state  <= IDLE;
        end else rx_timer <= rx_timer + 1'b1;
        default: rx_state <= IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 pop;
  logic                 wr;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign pop      = rx_valid && rx_ready;
  assign wr       = push && ((rx_count != C_FULL) || pop);
  assign rx_valid = (rx_count != '0);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr) rx_overrun <= 1'b1;
      case ({wr, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule
